// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply unit: operation codes, FSM states
// and small operation-class helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MUL   = 3'd2,
    OP_MADD  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } mdu_state_e;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL) || (op == OP_MADD);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD);
  endfunction

endpackage

// File: rtl/hilo_mult_unit_if.sv
// Request/result bundle between the pipeline (master) and the multiply unit (slave).
// Handshake: a request is taken on a rising edge where start=1, ready=1, cancel=0;
// done pulses for one cycle per completed op and never back-pressures.
interface hilo_mult_unit_if #(
  parameter int DATA_W = 32
);
  import mdu_pkg::*;

  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic              cancel;
  logic              ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] mulOut;
  logic [DATA_W-1:0] HI_out;
  logic [DATA_W-1:0] LO_out;
  mdu_state_e        dbg_state;

  modport master (
    output start, op, opA, opB, cancel,
    input  ready, busy, done, mulOut, HI_out, LO_out, dbg_state
  );

  modport slave (
    input  start, op, opA, opB, cancel,
    output ready, busy, done, mulOut, HI_out, LO_out, dbg_state
  );

endinterface

// File: rtl/mult_iter_datapath.sv
// Radix-2 shift-add multiplier core on unsigned magnitudes, one multiplier bit
// per step, with the step counter that paces the iteration.
module mult_iter_datapath #(
  parameter int DATA_W    = 32,
  parameter int ITER_BITS = $clog2(DATA_W) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  clear,
  input  logic [DATA_W-1:0]     mag_a,
  input  logic [DATA_W-1:0]     mag_b,
  output logic [2*DATA_W-1:0]   product,
  output logic                  last
);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [ITER_BITS-1:0] cnt_q, cnt_d;
  logic [DATA_W:0]     sum;

  // Upper half accumulates the partial sum, lower half holds the unconsumed
  // multiplier bits; each step shifts both right by one.
  always_comb begin
    sum     = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
              (acc_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    if (load) begin
      acc_d   = {{DATA_W{1'b0}}, mag_b};
      mcand_d = mag_a;
      cnt_d   = '0;
    end else if (step) begin
      acc_d = {sum, acc_q[DATA_W-1:1]};
      cnt_d = cnt_q + ITER_BITS'(1);
    end else if (clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign product = acc_q;
  assign last    = (cnt_q == ITER_BITS'(DATA_W - 1));

endmodule

// File: rtl/hilo_mult_unit.sv
// Iterative MIPS-style multiply unit owning the architectural HI/LO registers:
// FSM, operand sign handling and result commit around the shift-add core.
module hilo_mult_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ITER_BITS = $clog2(DATA_W) + 1
) (
  input  logic             Clk,
  input  logic             Rst,
  hilo_mult_unit_if.slave  bus
);

  mdu_state_e          state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, mul_q, mul_d;
  logic                done_q, done_d;

  logic                ready, busy, accept, load, step, clear, last;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [2*DATA_W-1:0] product, result;

  assign accept = bus.start && ready && !bus.cancel;

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_iter_op(bus.op)) state_d = ITER;
      ITER:    if (bus.cancel) state_d = IDLE;
               else if (last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q == ITER) || (state_q == FIN);
    load  = ready && accept && is_iter_op(bus.op);
    step  = (state_q == ITER);
    clear = (state_q != ITER);
  end

  // Magnitudes stay DATA_W-bit unsigned so the most-negative operand maps to 2^(DATA_W-1).
  always_comb begin
    mag_a = (is_signed_op(bus.op) && bus.opA[DATA_W-1]) ? -bus.opA : bus.opA;
    mag_b = (is_signed_op(bus.op) && bus.opB[DATA_W-1]) ? -bus.opB : bus.opB;
  end

  mult_iter_datapath #(
    .DATA_W    (DATA_W),
    .ITER_BITS (ITER_BITS)
  ) u_dp (
    .clk     (Clk),
    .rst     (Rst),
    .load    (load),
    .step    (step),
    .clear   (clear),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .product (product),
    .last    (last)
  );

  always_comb begin
    result = neg_q ? -product : product;
    op_d   = load ? bus.op : op_q;
    neg_d  = load ? (is_signed_op(bus.op) && (bus.opA[DATA_W-1] ^ bus.opB[DATA_W-1])) : neg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    mul_d  = mul_q;
    done_d = 1'b0;
    if (ready && accept) begin
      case (bus.op)
        OP_MTHI: begin hi_d = bus.opA; done_d = 1'b1; end
        OP_MTLO: begin lo_d = bus.opA; done_d = 1'b1; end
        default: ;
      endcase
    end
    if ((state_q == FIN) && !bus.cancel) begin
      done_d = 1'b1;
      case (op_q)
        OP_MULT, OP_MULTU: {hi_d, lo_d} = result;
        OP_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + result;
        OP_MUL:            mul_d = result[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      mul_q  <= '0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      neg_q  <= neg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      mul_q  <= mul_d;
      done_q <= done_d;
    end
  end

  assign bus.ready     = ready;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.mulOut    = mul_q;
  assign bus.HI_out    = hi_q;
  assign bus.LO_out    = lo_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit (DATA_W=32): reference model feeds a
// scoreboard queue at issue time; results are checked when done pulses.
module tb_hilo_mult_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;

  hilo_mult_unit_if #(.DATA_W(W)) bus ();

  hilo_mult_unit #(.DATA_W(W)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [3*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi, m_lo, m_mul;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb, p;
    if (op == OP_MULTU) begin
      ea = {{W{1'b0}}, a};
      eb = {{W{1'b0}}, b};
    end else begin
      ea = {{W{a[W-1]}}, a};
      eb = {{W{b[W-1]}}, b};
    end
    p = ea * eb;
    case (op)
      OP_MULT, OP_MULTU: {m_hi, m_lo} = p;
      OP_MADD:           {m_hi, m_lo} = {m_hi, m_lo} + p;
      OP_MUL:            m_mul = p[W-1:0];
      OP_MTHI:           m_hi = a;
      OP_MTLO:           m_lo = a;
      default: ;
    endcase
    exp_q.push_back({m_hi, m_lo, m_mul});
  endtask

  // ---------------- drivers ----------------
  // Called #1 after a rising edge; returns #1 after the edge that sampled start.
  task automatic pulse_start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int k0);
    int k;
    logic [3*W-1:0] e;
    k = k0;
    while (bus.done !== 1'b1 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_sb_pending"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_hi"},  bus.HI_out, e[3*W-1:2*W]);
      check({tag, "_lo"},  bus.LO_out, e[2*W-1:W]);
      check({tag, "_mul"}, bus.mulOut, e[W-1:0]);
    end
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    model_issue(op, a, b);
    pulse_start(op, a, b);
    wait_done(tag, is_iter_op(op) ? W + 1 : 0, 0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) pulses++;
    end
    check({tag, "_no_done"}, pulses, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] op_tab [6];
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    op_tab = '{OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MTHI, OP_MTLO};
    m_hi = '0; m_lo = '0; m_mul = '0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.opA = '0; bus.opB = '0; bus.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.ready, 1'b1);
    check("rst_busy",  bus.busy,  1'b0);
    check("rst_done",  bus.done,  1'b0);
    check("rst_hi",    bus.HI_out, 32'h0);
    check("rst_lo",    bus.LO_out, 32'h0);
    check("rst_mul",   bus.mulOut, 32'h0);
    rst = 1'b0;

    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_lit", bus.HI_out, 32'hFFFF_FFFE);
    check("multu_max_lo_lit", bus.LO_out, 32'h0000_0001);

    do_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg3x7_lo_lit", bus.LO_out, 32'hFFFF_FFEB);
    do_op("mult_minneg", OP_MULT, 32'h8000_0000, 32'h8000_0000);
    check("mult_minneg_hi_lit", bus.HI_out, 32'h4000_0000);
    do_op("mult_minneg_x1", OP_MULT, 32'h8000_0000, 32'd1);

    do_op("mthi_a", OP_MTHI, 32'hA, 32'h0);
    do_op("mtlo_b", OP_MTLO, 32'hB, 32'h0);
    do_op("mul_6x7", OP_MUL, 32'd6, 32'd7);
    check("mul_6x7_lit", bus.mulOut, 32'd42);
    do_op("mul_neg", OP_MUL, 32'hFFFF_FFFE, 32'd9);

    do_op("mthi_0", OP_MTHI, 32'h0, 32'h0);
    do_op("mtlo_ff", OP_MTLO, 32'hFFFF_FFFF, 32'h0);
    do_op("madd_carry", OP_MADD, 32'd1, 32'd1);
    check("madd_carry_hi_lit", bus.HI_out, 32'h1);
    do_op("mthi_ff", OP_MTHI, 32'hFFFF_FFFF, 32'h0);
    do_op("madd_wrap", OP_MADD, 32'd1, 32'd1);
    do_op("madd_neg", OP_MADD, 32'hFFFF_FFFE, 32'd3);

    // no-op code: not committed, no done
    pulse_start(3'd7, 32'd5, 32'd5);
    expect_quiet("noop_code", 40);

    // start together with cancel in IDLE is not taken
    bus.cancel = 1'b1;
    pulse_start(OP_MULT, 32'd5, 32'd5);
    bus.cancel = 1'b0;
    check("idle_cancel_busy", bus.busy, 1'b0);
    expect_quiet("idle_cancel", 40);

    // cancel mid-ITER
    pulse_start(OP_MULT, 32'd5, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    check("cancel_ready", bus.ready, 1'b1);
    check("cancel_busy",  bus.busy,  1'b0);
    check("cancel_hi",    bus.HI_out, m_hi);
    check("cancel_lo",    bus.LO_out, m_lo);
    expect_quiet("cancel", 40);
    check("cancel_hi_after", bus.HI_out, m_hi);
    do_op("after_cancel", OP_MULT, 32'd5, 32'd5);

    // start while busy is dropped
    model_issue(OP_MULT, 32'd3, 32'd4);
    pulse_start(OP_MULT, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    check("busy_not_ready", bus.ready, 1'b0);
    pulse_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("busy_start", W + 1, 5);
    expect_quiet("busy_start_dropped", 40);

    // reset mid-ITER
    pulse_start(OP_MULT, 32'd5, 32'd6);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_mul = '0;
    check("midrst_hi",    bus.HI_out, 32'h0);
    check("midrst_lo",    bus.LO_out, 32'h0);
    check("midrst_mul",   bus.mulOut, 32'h0);
    check("midrst_ready", bus.ready,  1'b1);
    check("midrst_done",  bus.done,   1'b0);
    expect_quiet("midrst", 40);

    for (int i = 0; i < 8; i++) begin
      rop = op_tab[$urandom_range(5, 0)];
      ra  = $urandom;
      rb  = $urandom;
      do_op("rand", rop, ra, rb);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_mult_unit.md
HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/HI/LO width; legal values are even numbers 8..64.
REQ-002 SHALL have parameter ITER_BITS, default $clog2(DATA_W)+1, iteration counter width.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Clk  in  1  rising-edge clock.
REQ-005 Rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  request; accepted only when ready=1.
REQ-007 op  in  3  operation code (package encodings).
REQ-008 opA, opB  in  DATA_W each  operands (rs, rt).
REQ-009 cancel  in  1  pipeline flush; aborts in-flight op.
REQ-010 ready  out  1  idle, can accept.
REQ-011 busy  out  1  iterative op in flight.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 mulOut  out  DATA_W  low half of the MUL product, valid while done=1.
REQ-014 HI_out, LO_out  out  DATA_W each  architectural HI/LO registers, always driven.

Function
REQ-015 Ops SHALL be: MULT (signed, write HI/LO); MULTU (unsigned, write HI/LO); MUL (signed, low half to mulOut, HI/LO unchanged); MADD (signed, {HI,LO} += product); MTHI (HI<=opA); MTLO (LO<=opA); other codes are no-ops.
REQ-016 FSM SHALL have states IDLE, ITER, FIN; ready=1 only in IDLE; busy=1 in ITER and FIN.
REQ-017 IDLE->ITER on start&ready&!cancel for MULT/MULTU/MUL/MADD; operands, op and sign info latched on that edge.
REQ-018 ITER SHALL run radix-2 shift-add on operand magnitudes, one bit per cycle, for exactly DATA_W cycles, then go to FIN.
REQ-019 In FIN, a signed result SHALL be negated when operand signs differ; the 2*DATA_W result SHALL be committed to HI/LO or mulOut per op; done=1; next state IDLE.
REQ-020 Latency: done SHALL assert exactly DATA_W+1 cycles after the accept edge; HI/LO SHALL update on the same edge done rises.
REQ-021 MTHI/MTLO SHALL complete in one cycle: register written on the accept edge, done=1 next cycle, no ITER.
REQ-022 MADD SHALL add modulo 2^(2*DATA_W); wrap-around is silent.
REQ-023 start while not ready SHALL be ignored; it is not queued.
REQ-024 cancel in ITER/FIN SHALL return to IDLE next edge, with no done pulse and HI/LO unchanged; cancel and start together in IDLE SHALL mean nothing is accepted.
REQ-025 Most-negative operand (e.g. 0x80000000) SHALL give the exact signed product, using a DATA_W-bit unsigned magnitude.
REQ-026 mulOut SHALL hold its last value when done=0.

Reset
REQ-027 Rst SHALL force IDLE, HI_out=0, LO_out=0, mulOut=0, done=0, busy=0, ready=1 and counter=0 on the next edge, including mid-operation; Rst has priority over cancel and start.

Structure
REQ-028 Op encodings and the FSM state enum SHALL reside in shared package mdu_pkg.
REQ-029 The shift-add accumulator/counter SHALL be sub-module mult_iter_datapath (params DATA_W, ITER_BITS); the FSM, sign handling and HI/LO stay in the top.

Verification (DATA_W=32)
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 33 cycles after accept; HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 MULT -3 (0xFFFFFFFD) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
REQ-032 MUL 6 x 7 with HI/LO preloaded to 0xA/0xB -> mulOut=42 while done=1, HI/LO stay 0xA/0xB.
REQ-033 MTHI 0 and MTLO 0xFFFFFFFF, then MADD 1 x 1 -> HI=0x00000001, LO=0x00000000.
REQ-034 MULT 5 x 5 with cancel asserted 10 cycles in -> no done, HI/LO unchanged, ready=1 next cycle; a repeated start is then accepted.
REQ-035 Rst asserted mid-ITER -> next edge HI/LO=0, ready=1, no done; start asserted while busy is ignored (check with a second op).
